jtag_tap_controller: RTL
========================

Name: jtag_tap_controller

Overview:
- IEEE 1149.1-style TAP responder for the boundary-scan wrapper of the DSP core; it is the device-side end of the TMS/TDI/TDO link driven by the tester.
- Contains the 16-state TAP FSM, a 3-bit instruction register, a 1-bit bypass register and the TDO output mux.
- Drives the capture/shift/update strobes and the mode/select controls for the external boundary-scan register (BSR) chain.

Parameters:
- IR_WIDTH, 3, instruction register width.
- IR_CAPTURE, 3'b001, value loaded into the IR shift stage in Capture-IR.
- RESET_INSTR, 3'b111, instruction loaded on reset or in Test-Logic-Reset (BYPASS).

Ports:
- TCLK  in  1  test clock; the only clock.
- TRST  in  1  asynchronous, active-high reset.
- TMS  in  1  mode select, sampled on posedge TCLK.
- TDI  in  1  serial data in, sampled on posedge TCLK.
- bsr_so  in  1  serial out of the BSR chain.
- bsr_si  out  1  serial in to the BSR chain; equals TDI.
- captureDR  out  1  high in Capture-DR while the BSR is selected.
- shiftDR  out  1  high in Shift-DR while the BSR is selected.
- updateDR  out  1  one-cycle pulse in Update-DR while the BSR is selected.
- mode  out  1  1 when the active instruction is INTEST or EXTEST.
- intest  out  1  1 when the active instruction is INTEST; gates core clock/reset handoff.
- instruction  out  3  active (updated) instruction.
- tap_state  out  4  current FSM state encoding.
- TDO  out  1  serial data out, registered on negedge TCLK.
- TDO_en  out  1  1 while in Shift-IR or Shift-DR; registered on negedge TCLK.

Behaviour:
- Reset values (TRST high):
  - tap_state = TLR.
  - instruction = RESET_INSTR.
  - IR shift stage = IR_CAPTURE.
  - bypass = 0, TDO = 0, TDO_en = 0.
  - All strobes = 0, mode = 0, intest = 0.
- FSM: standard 16 states, transitions on posedge TCLK.
  - TLR: TMS=0 -> RTI.
  - RTI: TMS=1 -> SelDR.
  - SelDR: TMS=0 -> CapDR, TMS=1 -> SelIR.
  - SelIR: TMS=0 -> CapIR, TMS=1 -> TLR.
  - Capture: TMS=0 -> Shift, TMS=1 -> Exit1.
  - Shift: TMS=1 -> Exit1, TMS=0 stays in Shift.
  - Exit1: TMS=0 -> Pause, TMS=1 -> Update.
  - Pause: TMS=1 -> Exit2.
  - Exit2: TMS=0 -> Shift, TMS=1 -> Update.
  - Update: TMS=0 -> RTI, TMS=1 -> SelDR.
  - Five consecutive TMS=1 cycles reach TLR from any state.
- State encoding: TLR=0xF, RTI=0xC, SelDR=0x7, CapDR=0x6, ShDR=0x2, Ex1DR=0x1, PauDR=0x3, Ex2DR=0x0, UpdDR=0x5, SelIR=0x4, CapIR=0xE, ShIR=0xA, Ex1IR=0x9, PauIR=0xB, Ex2IR=0x8, UpdIR=0xD.
- TLR: instruction forced to RESET_INSTR synchronously.
- IR path:
  - CapIR loads IR_CAPTURE into the shift stage.
  - ShIR shifts right, LSB first; TDI enters at the MSB.
  - Instruction is loaded from the shift stage on negedge TCLK while in UpdIR.
- Decode:
  - 111 BYPASS; 011 INTEST; 010 SAMPLE; 001 PRELOAD; 000 EXTEST.
  - 100/101/110 are treated as BYPASS.
  - BSR is selected for 000/001/010/011; bypass is selected otherwise.
- Bypass register: cleared in CapDR; loads TDI in ShDR. One cycle of latency from TDI to the TDO path.
- Strobes:
  - captureDR and shiftDR are combinational decodes of tap_state gated by BSR selection.
  - updateDR is high only while in UpdDR.
- TDO source, latched on negedge:
  - In ShIR: IR shift-stage LSB.
  - In ShDR: bsr_so or the bypass bit, per selection.
  - Otherwise TDO holds its previous value and TDO_en = 0.
- TRST asserted mid-shift: immediate return to reset values; a partially shifted IR is discarded and instruction becomes BYPASS.
- IR and DR shift on the same edge that samples TMS=1 into Exit1; the last bit is captured, which matches tester behaviour.

Decomposition:
- Shared package jtag_pkg holds:
  - the 4-bit state encoding constants;
  - the opcode constants BYPASS/INTEST/SAMPLE/PRELOAD/EXTEST;
  - the IR_WIDTH default.
- One sub-module, jtag_tap_fsm (state register plus next-state logic, tap_state output), is natural.
- IR, bypass register and TDO mux stay in the top module.

Test Plan:
- Reset/TLR: pulse TRST, then 5x TMS=1 from ShDR -> tap_state=0xF, instruction=111, TDO_en=0.
- IR load INTEST:
  - Stimulus: TMS 0,1,1,0,0, then shift TDI 1,1,0 with TMS=1 on the last bit, then UpdIR.
  - Response: TDO emits 1,0,0 (capture 001); instruction=011; mode=1; intest=1.
- Bypass shift: instruction=111; shift TDI 1,0,1,1,0 in ShDR -> TDO emits 0,1,0,1,1 (first bit is the captured 0); captureDR/shiftDR stay 0.
- BSR path: instruction=000; drive bsr_so pattern 1,0,1 in ShDR -> TDO follows bsr_so; shiftDR=1 for 3 cycles; updateDR pulses once in UpdDR.
- Illegal opcode: load 101 -> bypass selected; one-bit TDI->TDO delay; mode=0.
- Mid-operation reset: assert TRST after 2 of 3 IR shift bits -> tap_state=0xF immediately; instruction stays 111; a subsequent full 011 load succeeds.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared definitions for the boundary-scan TAP: state encoding, opcodes and
// the default instruction register width.
package jtag_pkg;

    localparam int DEFAULT_IR_WIDTH = 3;

    // The encoding is visible on tap_state, so every value is pinned explicitly.
    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [2:0] BYPASS  = 3'b111;
    localparam logic [2:0] INTEST  = 3'b011;
    localparam logic [2:0] SAMPLE  = 3'b010;
    localparam logic [2:0] PRELOAD = 3'b001;
    localparam logic [2:0] EXTEST  = 3'b000;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register and TMS-driven next-state logic.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCLK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_e tap_state
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            tap_state <= TLR;
        end else begin
            case (tap_state)
                TLR:     tap_state <= TMS ? TLR    : RTI;
                RTI:     tap_state <= TMS ? SEL_DR : RTI;
                SEL_DR:  tap_state <= TMS ? SEL_IR : CAP_DR;
                CAP_DR:  tap_state <= TMS ? EX1_DR : SH_DR;
                SH_DR:   tap_state <= TMS ? EX1_DR : SH_DR;
                EX1_DR:  tap_state <= TMS ? UPD_DR : PAU_DR;
                PAU_DR:  tap_state <= TMS ? EX2_DR : PAU_DR;
                EX2_DR:  tap_state <= TMS ? UPD_DR : SH_DR;
                UPD_DR:  tap_state <= TMS ? SEL_DR : RTI;
                SEL_IR:  tap_state <= TMS ? TLR    : CAP_IR;
                CAP_IR:  tap_state <= TMS ? EX1_IR : SH_IR;
                SH_IR:   tap_state <= TMS ? EX1_IR : SH_IR;
                EX1_IR:  tap_state <= TMS ? UPD_IR : PAU_IR;
                PAU_IR:  tap_state <= TMS ? EX2_IR : PAU_IR;
                EX2_IR:  tap_state <= TMS ? UPD_IR : SH_IR;
                UPD_IR:  tap_state <= TMS ? SEL_DR : RTI;
                default: tap_state <= TLR;
            endcase
        end
    end

endmodule

// File: rtl/jtag_tap_controller.sv
// Device-side TAP responder: FSM, instruction register, bypass register,
// negedge TDO mux and the control strobes for the external BSR chain.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int                  IR_WIDTH    = DEFAULT_IR_WIDTH,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(3'b001),
    parameter logic [IR_WIDTH-1:0] RESET_INSTR = IR_WIDTH'(BYPASS)
) (
    input  logic                TCLK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                bsr_so,
    output logic                bsr_si,
    output logic                captureDR,
    output logic                shiftDR,
    output logic                updateDR,
    output logic                mode,
    output logic                intest,
    output logic [IR_WIDTH-1:0] instruction,
    output logic [3:0]          tap_state,
    output logic                TDO,
    output logic                TDO_en
);

    tap_state_e          state;
    logic [IR_WIDTH-1:0] ir_shift;
    logic                bypass_reg;
    logic                sel_bsr;

    jtag_tap_fsm u_fsm (
        .TCLK      (TCLK),
        .TRST      (TRST),
        .TMS       (TMS),
        .tap_state (state)
    );

    assign tap_state = state;
    assign bsr_si    = TDI;

    // IR shift stage: TDI enters at the MSB, the LSB leaves first.
    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            ir_shift <= IR_CAPTURE;
        end else if (state == CAP_IR) begin
            ir_shift <= IR_CAPTURE;
        end else if (state == SH_IR) begin
            ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            bypass_reg <= 1'b0;
        end else if (state == CAP_DR) begin
            bypass_reg <= 1'b0;
        end else if (state == SH_DR) begin
            bypass_reg <= TDI;
        end
    end

    // Falling-edge side: the tester samples TDO on the next rising edge, and
    // the active instruction only changes mid-cycle in Update-IR or TLR.
    always_ff @(negedge TCLK or posedge TRST) begin
        if (TRST) begin
            instruction <= RESET_INSTR;
            TDO         <= 1'b0;
            TDO_en      <= 1'b0;
        end else begin
            TDO_en <= (state == SH_IR) || (state == SH_DR);
            if (state == SH_IR) begin
                TDO <= ir_shift[0];
            end else if (state == SH_DR) begin
                TDO <= sel_bsr ? bsr_so : bypass_reg;
            end

            if (state == TLR) begin
                instruction <= RESET_INSTR;
            end else if (state == UPD_IR) begin
                instruction <= ir_shift;
            end
        end
    end

    // Unlisted opcodes fall through to the defaults and behave as BYPASS.
    always_comb begin
        // NOTE: defaults first so no case path leaves an output unassigned,
        // which would otherwise infer a latch.
        sel_bsr = 1'b0;
        mode    = 1'b0;
        intest  = 1'b0;
        case (instruction)
            IR_WIDTH'(EXTEST): begin
                sel_bsr = 1'b1;
                mode    = 1'b1;
            end
            IR_WIDTH'(INTEST): begin
                sel_bsr = 1'b1;
                mode    = 1'b1;
                intest  = 1'b1;
            end
            IR_WIDTH'(SAMPLE), IR_WIDTH'(PRELOAD): begin
                sel_bsr = 1'b1;
            end
            default: ;
        endcase
    end

    assign captureDR = sel_bsr && (state == CAP_DR);
    assign shiftDR   = sel_bsr && (state == SH_DR);
    assign updateDR  = sel_bsr && (state == UPD_DR);

endmodule
